apb_exe_requester: RTL and testbench

APB3 requester (initiator) that drives an APB-attached execution unit on behalf of a local command interface.
- Accepts one operation (opcode, argA, argB) on a valid/ready handshake.
- Issues APB writes for ARG_A, ARG_B and CTRL, then an APB read of RESULT.
- Returns result, unit error flag and bus-error flag on a valid/ready response channel.
- Sits between the system-side sequencer and the exe-unit APB completer; it is the bus-driving end of that link.

---
 rtl/exe_pkg.sv | 33 +++
 rtl/apb_timeout_cnt.sv | 30 +++
 rtl/apb_exe_requester.sv | 186 ++++++++++++++++++
 tb/tb_apb_exe_requester.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types and register map for the APB execution-unit requester.
// Register offsets are relative to the unit's base address.
package exe_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NEG = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5
  } op_e;

  localparam logic [3:0] REG_ARG_A  = 4'h0;
  localparam logic [3:0] REG_ARG_B  = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_RESULT = 4'hC;

  localparam int CTRL_START_BIT = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {WR_A, WR_B, WR_CTRL, RD_RES} step_e;

  function automatic logic [3:0] step_offset(input step_e s);
    case (s)
      WR_A:    return REG_ARG_A;
      WR_B:    return REG_ARG_B;
      WR_CTRL: return REG_CTRL;
      default: return REG_RESULT;
    endcase
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state watchdog: loaded on clear, counts down while enabled, and flags
// expiry on the TIMEOUT-th enabled cycle since the last clear.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= LOAD;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == CW'(1));

endmodule

// File: rtl/apb_exe_requester.sv
// APB3 requester: writes ARG_A, ARG_B, CTRL to the execution unit, reads RESULT
// and hands result/error/bus-error back on a valid/ready response channel.
//
// state  | meaning
// IDLE   | waiting for a command, o_cmd_ready=1, bus idle
// SETUP  | APB setup phase for the current step (psel=1, penable=0)
// ACCESS | APB access phase, waiting for PREADY (timeout guarded)
// RESP   | response held on o_rsp_* until i_rsp_ready
module apb_exe_requester
  import exe_pkg::*;
#(
  parameter int                BITS      = 4,
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_op,
  input  logic [BITS-1:0]   i_cmd_argA,
  input  logic [BITS-1:0]   i_cmd_argB,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [BITS-1:0]   o_rsp_result,
  output logic              o_rsp_error,
  output logic              o_rsp_buserr,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  state_e          r_state;
  step_e           r_step;
  op_e             r_op;
  logic [BITS-1:0] r_arg_a;
  logic [BITS-1:0] r_arg_b;
  logic [BITS-1:0] r_result;
  logic            r_error;
  logic            r_buserr;

  state_e w_state_nxt;
  step_e  w_step_nxt;
  logic   w_accept;
  logic   w_done;
  logic   w_abort;
  logic   w_release;
  logic   w_cnt_clear;
  logic   w_cnt_en;
  logic   w_expired;
  logic   w_active;
  logic   w_unused_prdata;

  // Only RESULT[BITS:0] carries information; upper read bits are ignored.
  assign w_unused_prdata = ^i_prdata;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_step   <= WR_A;
      r_op     <= OP_ADD;
      r_arg_a  <= '0;
      r_arg_b  <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_buserr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      if (w_accept) begin
        r_op    <= op_e'(i_cmd_op);
        r_arg_a <= i_cmd_argA;
        r_arg_b <= i_cmd_argB;
      end
      if (w_done) begin
        r_result <= i_prdata[BITS-1:0];
        r_error  <= i_prdata[BITS];
        r_buserr <= 1'b0;
      end else if (w_abort) begin
        r_result <= '0;
        r_error  <= 1'b0;
        r_buserr <= 1'b1;
      end else if (w_release) begin
        r_result <= '0;
        r_error  <= 1'b0;
        r_buserr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_release   = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_step_nxt  = WR_A;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_cnt_clear = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (i_pready) begin
          if (i_pslverr) begin
            w_abort     = 1'b1;
            w_state_nxt = RESP;
          end else if (r_step == RD_RES) begin
            w_done      = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_step_nxt  = step_e'(r_step + 2'd1);
            w_state_nxt = SETUP;
          end
        end else begin
          w_cnt_en = 1'b1;
          if (w_expired) begin
            w_abort     = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  assign w_active  = (r_state == SETUP) || (r_state == ACCESS);
  assign o_psel    = w_active;
  assign o_penable = (r_state == ACCESS);

  always_comb begin
    o_paddr  = '0;
    o_pwdata = '0;
    o_pwrite = 1'b0;
    if (w_active) begin
      o_paddr  = BASE_ADDR + ADDR_W'(step_offset(r_step));
      o_pwrite = (r_step != RD_RES);
      case (r_step)
        WR_A:    o_pwdata = DATA_W'(r_arg_a);
        WR_B:    o_pwdata = DATA_W'(r_arg_b);
        WR_CTRL: o_pwdata = DATA_W'(r_op) | (DATA_W'(1) << CTRL_START_BIT);
        default: o_pwdata = '0;
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == IDLE);
  assign o_rsp_valid  = (r_state == RESP);
  assign o_rsp_result = r_result;
  assign o_rsp_error  = r_error;
  assign o_rsp_buserr = r_buserr;

endmodule

// File: tb/tb_apb_exe_requester.sv
// Directed plus randomized bench for apb_exe_requester against a behavioural
// APB execution-unit completer with configurable wait states and errors.
module tb_apb_exe_requester;
  import exe_pkg::*;

  localparam int BITS = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TIMEOUT = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [3:0]        i_cmd_op = '0;
  logic [BITS-1:0]   i_cmd_argA = '0;
  logic [BITS-1:0]   i_cmd_argB = '0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [BITS-1:0]   o_rsp_result;
  logic              o_rsp_error;
  logic              o_rsp_buserr;
  logic [ADDR_W-1:0] o_paddr;
  logic              o_psel;
  logic              o_penable;
  logic              o_pwrite;
  logic [DATA_W-1:0] o_pwdata;
  logic [DATA_W-1:0] i_prdata;
  logic              i_pready;
  logic              i_pslverr;

  always #5 i_clk = ~i_clk;

  apb_exe_requester #(
    .BITS(BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(8'h00), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_argA(i_cmd_argA), .i_cmd_argB(i_cmd_argB),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_result(o_rsp_result),
    .o_rsp_error(o_rsp_error), .o_rsp_buserr(o_rsp_buserr),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_pwdata(o_pwdata), .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Completer model configuration (written only by the stimulus block).
  int cfg_wait[4];
  int cfg_err_idx = -1;
  bit cfg_stuck = 1'b0;

  // Completer model state and bus observations (written only by always blocks).
  logic [7:0]  cpl_wait = '0;
  logic [31:0] cpl_regs[4];
  logic [40:0] log_q[$];
  int          access_cycles = 0;
  int          stab_err = 0;
  bit          prev_pend = 1'b0;
  logic [40:0] prev_bus = '0;
  logic [5:0]  last_payload;

  // Execution unit behaviour: RESULT[3:0] is the value, RESULT[4] the unit error.
  function automatic logic [31:0] exe_eval(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic [31:0] rc);
    logic [4:0] a, b, r;
    a = {1'b0, ra[3:0]};
    b = {1'b0, rb[3:0]};
    if (!rc[4]) return 32'hDEAD0000;
    case (rc[3:0])
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = {a[3:0] == 4'h8, 4'(5'd0 - a)};
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      default: r = 5'd0;
    endcase
    return {27'd0, r};
  endfunction

  assign i_pready  = o_psel && o_penable && !cfg_stuck && (cpl_wait == 8'd0);
  assign i_pslverr = i_pready && (cfg_err_idx >= 0) && (o_paddr[3:2] == cfg_err_idx[1:0]);
  assign i_prdata  = (o_psel && o_penable && !o_pwrite) ?
                     exe_eval(cpl_regs[0], cpl_regs[1], cpl_regs[2]) : 32'h0;

  always @(posedge i_clk) begin
    if (o_psel && !o_penable) cpl_wait <= 8'(cfg_wait[o_paddr[3:2]]);
    else if (o_psel && o_penable && cpl_wait != 8'd0) cpl_wait <= cpl_wait - 8'd1;
    if (o_psel && o_penable && i_pready) begin
      log_q.push_back({o_pwrite, o_paddr, o_pwdata});
      if (o_pwrite && !i_pslverr) cpl_regs[o_paddr[3:2]] <= o_pwdata;
    end
    if (o_psel && o_penable) access_cycles <= access_cycles + 1;
    if (o_psel && o_penable && prev_pend && ({o_pwrite, o_paddr, o_pwdata} != prev_bus))
      stab_err <= stab_err + 1;
    prev_pend <= o_psel && o_penable && !i_pready;
    prev_bus  <= {o_pwrite, o_paddr, o_pwdata};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    chk("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_argA  = a;
    i_cmd_argB  = b;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (o_rsp_valid !== 1'b1 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("rsp_wait_bound", 64'(n < 200), 64'd1);
  endtask

  task automatic consume();
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    chk("rsp_released", 64'({o_rsp_valid, o_cmd_ready}), 64'b01);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int exp_lat);
    int base, n;
    logic [31:0] e;
    logic [40:0] x[4];
    base = log_q.size();
    issue(op, a, b);
    wait_rsp(n);
    chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
    e = exe_eval({28'd0, a}, {28'd0, b}, {27'd0, 1'b1, op});
    last_payload = {o_rsp_buserr, o_rsp_error, o_rsp_result};
    chk({tag, ".payload"}, 64'(last_payload), 64'({1'b0, e[4:0]}));
    chk({tag, ".nxfer"}, 64'(log_q.size() - base), 64'd4);
    x[0] = {1'b1, 8'h00, 28'd0, a};
    x[1] = {1'b1, 8'h04, 28'd0, b};
    x[2] = {1'b1, 8'h08, 27'd0, 1'b1, op};
    x[3] = {1'b0, 8'h0C, 32'd0};
    if (log_q.size() - base == 4)
      for (int i = 0; i < 4; i++) chk({tag, ".xfer"}, 64'(log_q[base+i]), 64'(x[i]));
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, acc;
    int sum;
    logic [3:0] op, a, b;
    logic [31:0] e;

    for (int i = 0; i < 4; i++) cfg_wait[i] = 0;

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset.outputs", 64'({o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid,
                              o_rsp_result, o_rsp_error, o_rsp_buserr}), 64'd0);
    chk("reset.cmd_ready", 64'(o_cmd_ready), 64'd1);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    run_op("neg1", OP_NEG, 4'b0001, 4'b0000, 8);
    chk("neg1.literal", 64'(last_payload), 64'b001111);
    run_op("neg8", OP_NEG, 4'b1000, 4'b0000, 8);
    chk("neg8.literal", 64'(last_payload), 64'b011000);

    cfg_wait[1] = 3;
    acc = access_cycles;
    run_op("waitB", OP_ADD, 4'd5, 4'd6, 11);
    chk("waitB.access_cycles", 64'(access_cycles - acc), 64'd7);
    chk("waitB.stable", 64'(stab_err), 64'd0);
    cfg_wait[1] = 0;

    cfg_err_idx = 2;
    base = log_q.size();
    issue(OP_XOR, 4'd3, 4'd5);
    wait_rsp(n);
    chk("slverr.latency", 64'(n), 64'd6);
    chk("slverr.payload", 64'({o_rsp_buserr, o_rsp_error, o_rsp_result}), 64'b100000);
    chk("slverr.nxfer", 64'(log_q.size() - base), 64'd3);
    consume();
    cfg_err_idx = -1;

    cfg_stuck = 1'b1;
    issue(OP_ADD, 4'd1, 4'd1);
    acc = access_cycles;
    wait_rsp(n);
    chk("timeout.latency", 64'(n), 64'd17);
    chk("timeout.access_cycles", 64'(access_cycles - acc), 64'd16);
    chk("timeout.bus_idle", 64'({o_psel, o_penable}), 64'd0);
    chk("timeout.payload", 64'({o_rsp_buserr, o_rsp_error, o_rsp_result}), 64'b100000);
    consume();
    cfg_stuck = 1'b0;

    issue(OP_OR, 4'hA, 4'h5);
    wait_rsp(n);
    e = exe_eval(32'hA, 32'h5, 32'h14);
    i_cmd_valid = 1'b1;
    repeat (5) begin
      @(posedge i_clk);
      #1;
      chk("hold.cmd_ready", 64'({o_cmd_ready, o_rsp_valid}), 64'b01);
      chk("hold.payload", 64'({o_rsp_buserr, o_rsp_error, o_rsp_result}), 64'({1'b0, e[4:0]}));
    end
    i_cmd_valid = 1'b0;
    consume();

    cfg_stuck = 1'b1;
    issue(OP_SUB, 4'd9, 4'd3);
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst.in_access", 64'({o_psel, o_penable}), 64'b11);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst.async_outputs", 64'({o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid,
                                  o_rsp_result, o_rsp_error, o_rsp_buserr}), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cfg_stuck = 1'b0;
    chk("rst.no_rsp", 64'({o_rsp_valid, o_cmd_ready}), 64'b01);
    run_op("post_rst", OP_SUB, 4'd9, 4'd3, 8);

    for (int i = 0; i < 12; i++) begin
      sum = 0;
      for (int j = 0; j < 4; j++) begin
        cfg_wait[j] = int'($urandom_range(0, 2));
        sum += cfg_wait[j];
      end
      op = 4'($urandom_range(0, 5));
      a  = 4'($urandom);
      b  = 4'($urandom);
      run_op("rand", op, a, b, 8 + sum);
    end
    for (int j = 0; j < 4; j++) cfg_wait[j] = 0;

    chk("access_stability", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
